// File: rtl/vector_operand_streamer_pkg.sv
// Shared definitions for the vector operand streamer: element width codes,
// FSM state encoding and width lookup helpers.
package vector_operand_streamer_pkg;

    localparam logic [2:0] ONE_BYTE   = 3'd0;
    localparam logic [2:0] TWO_BYTE   = 3'd1;
    localparam logic [2:0] FOUR_BYTE  = 3'd2;
    localparam logic [2:0] EIGHT_BYTE = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    function automatic logic dtype_valid(input logic [2:0] dt);
        logic ok;
        case (dt)
            ONE_BYTE, TWO_BYTE, FOUR_BYTE, EIGHT_BYTE: ok = 1'b1;
            default:                                   ok = 1'b0;
        endcase
        return ok;
    endfunction

    // log2 of the element width in bits; max element count is VLEN >> this.
    function automatic logic [2:0] ew_log2(input logic [2:0] dt);
        logic [2:0] lg;
        case (dt)
            ONE_BYTE:   lg = 3'd3;
            TWO_BYTE:   lg = 3'd4;
            FOUR_BYTE:  lg = 3'd5;
            EIGHT_BYTE: lg = 3'd6;
            default:    lg = 3'd3;
        endcase
        return lg;
    endfunction

endpackage

// File: rtl/vector_element_select.sv
// Combinational extraction of element i (width set by data_type) from a
// vector register image, zero-extended to the element output width.
module vector_element_select
    import vector_operand_streamer_pkg::*;
#(
    parameter int VLEN     = 256,
    parameter int ELEM_LEN = 64,
    parameter int IDX_LEN  = 6
) (
    input  logic [VLEN-1:0]     i_vec,
    input  logic [IDX_LEN-1:0]  i_index,
    input  logic [2:0]          i_data_type,
    output logic [ELEM_LEN-1:0] o_elem
);

    logic [31:0]         w_shamt;
    logic [ELEM_LEN-1:0] w_low;
    logic [ELEM_LEN-1:0] w_mask;

    always_comb begin
        w_shamt = 32'(i_index) << ew_log2(i_data_type);
        w_low   = ELEM_LEN'(i_vec >> w_shamt);
        // A shift by the full width yields zero, so 64-bit elements get an all-ones mask.
        w_mask  = (ELEM_LEN'(1) << (32'd1 << ew_log2(i_data_type))) - ELEM_LEN'(1);
        o_elem  = w_low & w_mask;
    end

endmodule

// File: rtl/vector_operand_streamer.sv
// Snapshots two source vectors and the v0 mask at issue, then streams them
// one element per valid/ready handshake with index, mask-active and last tags.
module vector_operand_streamer
    import vector_operand_streamer_pkg::*;
#(
    parameter int DATA_LEN    = 32,
    parameter int VECTOR_SIZE = 8,
    parameter int ELEM_LEN    = 64,
    parameter int IDX_LEN     = 6,
    localparam int VLEN       = VECTOR_SIZE * DATA_LEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy_in,
    input  logic                start,
    input  logic                vm,
    input  logic [DATA_LEN-1:0] length,
    input  logic [2:0]          data_type,
    input  logic [VLEN-1:0]     v0_data,
    input  logic [VLEN-1:0]     rs1_data,
    input  logic [VLEN-1:0]     rs2_data,
    output logic                busy,
    output logic                elem_valid,
    input  logic                elem_ready,
    output logic [IDX_LEN-1:0]  elem_index,
    output logic [ELEM_LEN-1:0] elem_a,
    output logic [ELEM_LEN-1:0] elem_b,
    output logic                elem_active,
    output logic                elem_last,
    output logic                done,
    output logic                err,
    output state_t              dbg_state
);

    localparam int VW = $clog2(VLEN);

    // Handshake: an element moves on a rising edge where elem_valid, elem_ready
    // and rdy_in are all high; outputs then hold until that edge occurs.
    state_t              r_state;
    logic [VLEN-1:0]     r_v0, r_rs1, r_rs2;
    logic                r_vm;
    logic [2:0]          r_dtype;
    logic [IDX_LEN-1:0]  r_eff_len, r_index;
    logic [ELEM_LEN-1:0] r_a, r_b;
    logic                r_active, r_last, r_valid, r_busy, r_done, r_err;

    state_t              w_next_state;
    logic                w_load, w_adv, w_elem_load, w_type_ok;
    logic [DATA_LEN-1:0] w_max_len;
    logic [IDX_LEN-1:0]  w_eff_len, w_sel_idx, w_sel_len;
    logic [VLEN-1:0]     w_sel_v0, w_sel_rs1, w_sel_rs2;
    logic [2:0]          w_sel_dtype;
    logic                w_sel_vm, w_sel_active, w_sel_last;
    logic [ELEM_LEN-1:0] w_sel_a, w_sel_b;

    // Clamp at full DATA_LEN width so oversized vl values never alias after truncation.
    always_comb begin
        w_type_ok = dtype_valid(data_type);
        w_max_len = DATA_LEN'(VLEN) >> ew_log2(data_type);
        w_eff_len = (length < w_max_len) ? length[IDX_LEN-1:0] : w_max_len[IDX_LEN-1:0];
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_adv        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_next_state = (!w_type_ok || w_eff_len == '0) ? ST_FINISH : ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (elem_ready) begin
                    if (r_last) w_next_state = ST_FINISH;
                    else        w_adv        = 1'b1;
                end
            end
            ST_FINISH: w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // The next element is selected from the live inputs on issue, else from the snapshot.
    always_comb begin
        w_sel_idx    = w_load ? '0 : r_index + IDX_LEN'(1);
        w_sel_len    = w_load ? w_eff_len : r_eff_len;
        w_sel_v0     = w_load ? v0_data   : r_v0;
        w_sel_rs1    = w_load ? rs1_data  : r_rs1;
        w_sel_rs2    = w_load ? rs2_data  : r_rs2;
        w_sel_dtype  = w_load ? data_type : r_dtype;
        w_sel_vm     = w_load ? vm        : r_vm;
        w_sel_active = w_sel_vm | w_sel_v0[VW'(w_sel_idx)];
        w_sel_last   = (w_sel_idx == w_sel_len - IDX_LEN'(1));
        w_elem_load  = w_adv | (w_load & (w_next_state == ST_STREAM));
    end

    vector_element_select #(.VLEN(VLEN), .ELEM_LEN(ELEM_LEN), .IDX_LEN(IDX_LEN)) u_sel_a (
        .i_vec(w_sel_rs1), .i_index(w_sel_idx), .i_data_type(w_sel_dtype), .o_elem(w_sel_a)
    );

    vector_element_select #(.VLEN(VLEN), .ELEM_LEN(ELEM_LEN), .IDX_LEN(IDX_LEN)) u_sel_b (
        .i_vec(w_sel_rs2), .i_index(w_sel_idx), .i_data_type(w_sel_dtype), .o_elem(w_sel_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_v0      <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_vm      <= 1'b0;
            r_dtype   <= '0;
            r_eff_len <= '0;
            r_index   <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_active  <= 1'b0;
            r_last    <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else if (rdy_in) begin
            r_state <= w_next_state;
            r_valid <= (w_next_state == ST_STREAM);
            r_busy  <= (w_next_state != ST_IDLE);
            r_done  <= (w_next_state == ST_FINISH);
            r_err   <= w_load & ~w_type_ok;
            if (w_load) begin
                r_v0      <= v0_data;
                r_rs1     <= rs1_data;
                r_rs2     <= rs2_data;
                r_vm      <= vm;
                r_dtype   <= data_type;
                r_eff_len <= w_eff_len;
            end
            if (w_elem_load) begin
                r_index  <= w_sel_idx;
                r_a      <= w_sel_a;
                r_b      <= w_sel_b;
                r_active <= w_sel_active;
                r_last   <= w_sel_last;
            end
        end
    end

    assign busy        = r_busy;
    assign elem_valid  = r_valid;
    assign elem_index  = r_index;
    assign elem_a      = r_a;
    assign elem_b      = r_b;
    assign elem_active = r_active;
    assign elem_last   = r_last;
    assign done        = r_done;
    assign err         = r_err;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_vector_operand_streamer.sv
// Directed bench for vector_operand_streamer: a queue-based element model
// checked every cycle, plus hand-computed expectations per scenario.
module tb_vector_operand_streamer;
    import vector_operand_streamer_pkg::*;

    localparam int VLEN = 256;
    localparam int BW   = 6 + 64 + 64 + 1 + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            rdy_in, start, vm, elem_ready;
    logic [31:0]     length;
    logic [2:0]      data_type;
    logic [VLEN-1:0] v0_data, rs1_data, rs2_data;
    logic            busy, elem_valid, elem_active, elem_last, done, err;
    logic [5:0]      elem_index;
    logic [63:0]     elem_a, elem_b;
    state_t          dbg_state;

    vector_operand_streamer dut (
        .clk(clk), .rst(rst), .rdy_in(rdy_in), .start(start), .vm(vm),
        .length(length), .data_type(data_type), .v0_data(v0_data),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .busy(busy),
        .elem_valid(elem_valid), .elem_ready(elem_ready), .elem_index(elem_index),
        .elem_a(elem_a), .elem_b(elem_b), .elem_active(elem_active),
        .elem_last(elem_last), .done(done), .err(err), .dbg_state(dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [139:0] act, input logic [139:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- model / scoreboard ----------------
    logic [BW-1:0] exp_q[$];
    logic          exp_err    = 1'b0;
    logic          model_busy = 1'b0;
    logic [63:0]   got_a[$];
    logic          got_act[$];
    int            done_seen = 0, err_seen = 0, done_cyc = 0, start_cyc = 0;

    task automatic model_issue(input logic [2:0] dt, input logic [31:0] len, input logic v,
                               input logic [VLEN-1:0] m, input logic [VLEN-1:0] a,
                               input logic [VLEN-1:0] b);
        int ew, n;
        logic [VLEN-1:0] ta, tb;
        logic [63:0] mask;
        case (dt)
            3'd0: ew = 8;
            3'd1: ew = 16;
            3'd2: ew = 32;
            3'd3: ew = 64;
            default: ew = 0;
        endcase
        exp_err    = (ew == 0);
        model_busy = 1'b1;
        if (ew == 0) n = 0;
        else n = (64'(len) < 64'(VLEN / ew)) ? int'(len) : VLEN / ew;
        mask = (ew == 64) ? '1 : ((64'd1 << ew) - 64'd1);
        for (int i = 0; i < n; i++) begin
            ta = a >> (i * ew);
            tb = b >> (i * ew);
            exp_q.push_back({6'(i), ta[63:0] & mask, tb[63:0] & mask, v | m[i], i == n - 1});
        end
    endtask

    // ---------------- compare process ----------------
    logic          prev_stall = 1'b0;
    logic [139:0]  prev_out;
    logic [BW-1:0] e;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", {elem_valid, elem_index, elem_a, elem_b, elem_active, elem_last}, prev_out);
            chk("busy", busy, model_busy);
            if (elem_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", elem_index, 6'h3f);
                end else if (elem_ready && rdy_in) begin
                    e = exp_q.pop_front();
                    chk("beat", {elem_index, elem_a, elem_b, elem_active, elem_last}, e);
                    got_a.push_back(elem_a);
                    got_act.push_back(elem_active);
                end
            end
            if (err) err_seen++;
            if (done) begin
                chk("done_drained", exp_q.size(), 0);
                chk("err_at_done", err, exp_err);
                done_seen++;
                done_cyc   = cyc;
                model_busy = 1'b0;
            end else if (err) begin
                chk("err_without_done", err, 1'b0);
            end
            prev_stall = elem_valid && !(elem_ready && rdy_in);
            prev_out   = {elem_valid, elem_index, elem_a, elem_b, elem_active, elem_last};
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [VLEN-1:0] rand_vec();
        logic [VLEN-1:0] r;
        for (int i = 0; i < VLEN / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic clear_got();
        got_a.delete();
        got_act.delete();
    endtask

    task automatic issue(input logic [2:0] dt, input logic [31:0] len, input logic v,
                         input logic [VLEN-1:0] m, input logic [VLEN-1:0] a,
                         input logic [VLEN-1:0] b);
        @(posedge clk); #1;
        rdy_in = 1'b1; data_type = dt; length = len; vm = v;
        v0_data = m; rs1_data = a; rs2_data = b; start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        model_issue(dt, len, v, m, a, b);
        // Scramble the inputs; only the snapshot may matter from here on.
        v0_data = rand_vec(); rs1_data = rand_vec(); rs2_data = rand_vec();
        data_type = 3'($urandom_range(0, 7)); length = $urandom; vm = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(input int budget, input string name);
        int d0 = done_seen;
        for (int k = 0; k < budget && done_seen == d0; k++) @(posedge clk);
        if (done_seen == d0) chk({name, "_timeout"}, 0, 1);
    endtask

    // ---------------- stimulus ----------------
    logic [VLEN-1:0] va;
    logic [4:0]      av;
    bit              pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int              d0;

    initial begin
        rdy_in = 1'b1; start = 1'b0; vm = 1'b0; elem_ready = 1'b1;
        length = '0; data_type = '0; v0_data = '0; rs1_data = '0; rs2_data = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", elem_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_index", elem_index, 0);
        chk("rst_a", elem_a, 0);
        chk("rst_b", elem_b, 0);
        chk("rst_active_last", {elem_active, elem_last}, 0);

        // FOUR_BYTE, 8 elements, word i = i + 0x10
        for (int i = 0; i < 8; i++) va[i*32 +: 32] = 32'(i + 16);
        clear_got();
        issue(FOUR_BYTE, 32'd8, 1'b1, rand_vec(), va, rand_vec());
        wait_done(100, "t1");
        chk("t1_beats", got_a.size(), 8);
        chk("t1_a0", got_a[0], 64'h10);
        chk("t1_a7", got_a[7], 64'h17);
        chk("t1_done_cycle", done_cyc - start_cyc, 9);

        // ONE_BYTE masked, 5 elements
        va = '0;
        va[63:0] = 64'h0807_0605_0403_0201;
        clear_got();
        issue(ONE_BYTE, 32'd5, 1'b0, 256'b10110, va, rand_vec());
        wait_done(100, "t2");
        chk("t2_beats", got_a.size(), 5);
        for (int i = 0; i < 5; i++) av[i] = got_act[i];
        chk("t2_active", av, 5'b10110);
        chk("t2_byte2", got_a[2], 64'h03);
        chk("t2_byte4", got_a[4], 64'h05);

        // EIGHT_BYTE clamps to 4
        va = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC, 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        clear_got();
        issue(EIGHT_BYTE, 32'd100, 1'b1, rand_vec(), va, rand_vec());
        wait_done(100, "t3");
        chk("t3_beats", got_a.size(), 4);
        chk("t3_a3", got_a[3], 64'hDDDD_DDDD_DDDD_DDDD);

        // TWO_BYTE with all-ones length clamps to 16
        clear_got();
        issue(TWO_BYTE, 32'hFFFF_FFFF, 1'b0, rand_vec(), rand_vec(), rand_vec());
        wait_done(100, "t3b");
        chk("t3b_beats", got_a.size(), 16);

        // length 0
        clear_got();
        issue(FOUR_BYTE, 32'd0, 1'b1, rand_vec(), rand_vec(), rand_vec());
        wait_done(20, "t4");
        chk("t4_beats", got_a.size(), 0);
        chk("t4_done_cycle", done_cyc - start_cyc, 1);

        // invalid data_type
        clear_got();
        d0 = err_seen;
        issue(3'd6, 32'd4, 1'b1, rand_vec(), rand_vec(), rand_vec());
        wait_done(20, "t5");
        chk("t5_beats", got_a.size(), 0);
        chk("t5_err_pulses", err_seen - d0, 1);
        chk("t5_done_cycle", done_cyc - start_cyc, 1);

        // backpressure and rdy_in freeze
        clear_got();
        issue(FOUR_BYTE, 32'd8, 1'b0, rand_vec(), rand_vec(), rand_vec());
        d0 = done_seen;
        for (int k = 0; k < 80 && done_seen == d0; k++) begin
            @(posedge clk); #1;
            elem_ready = pat[k % 4];
            rdy_in     = !(k == 5 || k == 6);
        end
        if (done_seen == d0) chk("t6_timeout", 0, 1);
        elem_ready = 1'b1; rdy_in = 1'b1;
        chk("t6_beats", got_a.size(), 8);

        // asynchronous reset at element 3
        clear_got();
        issue(FOUR_BYTE, 32'd8, 1'b1, rand_vec(), rand_vec(), rand_vec());
        for (int k = 0; k < 50 && !(elem_valid && elem_index == 6'd3); k++) @(negedge clk);
        chk("t7_reached_idx3", {elem_valid, elem_index}, {1'b1, 6'd3});
        d0 = done_seen;
        #2 rst = 1'b1;
        #1;
        chk("t7_rst_valid", elem_valid, 0);
        chk("t7_rst_busy", busy, 0);
        chk("t7_rst_index", elem_index, 0);
        chk("t7_rst_a", elem_a, 0);
        exp_q.delete();
        model_busy = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        chk("t7_no_done", done_seen - d0, 0);
        clear_got();
        va = '0;
        va[47:0] = 48'h0033_0022_0011;
        issue(TWO_BYTE, 32'd3, 1'b1, rand_vec(), va, rand_vec());
        wait_done(50, "t7b");
        chk("t7_restart_beats", got_a.size(), 3);
        chk("t7_restart_a0", got_a[0], 64'h11);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
